// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory responder and its program loader.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam int unsigned IMEM_WORDS_DEF = 64;
    localparam int unsigned DMEM_BYTES_DEF = 256;
    localparam int unsigned BYTE_CNT_W     = 2;
    localparam int unsigned WORD_IDX_W     = 6;

endpackage

// File: rtl/mips_mem_loader.sv
// Program loader: assembles big-endian bytes into words, writes them into
// instruction memory, and sequences LOAD -> RELEASE -> RUN for the core reset.
module mips_mem_loader
    import mips_mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  core_rst,
    output state_e                state,
    output logic                  imem_we,
    output logic [WORD_IDX_W-1:0] imem_waddr,
    output logic [31:0]           imem_wdata
);

    state_e                state_q, state_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WORD_IDX_W-1:0] word_idx_q, word_idx_d;
    logic [31:0]           asm_q, asm_d;
    logic                  load_ready_q, load_ready_d;
    logic                  core_rst_q, core_rst_d;
    logic [31:0]           merged;
    logic                  accept;

    // Slots not yet filled are still zero, so a short final word is zero-padded.
    assign merged = asm_q | ({load_data, 24'h0} >> {byte_cnt_q, 3'b000});
    assign accept = load_valid && load_ready_q && !rst;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        imem_we    = 1'b0;
        imem_waddr = word_idx_q;
        imem_wdata = merged;
        unique case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (byte_cnt_q == BYTE_CNT_W'(3) || load_last) begin
                        imem_we    = 1'b1;
                        asm_d      = '0;
                        byte_cnt_d = '0;
                        if (load_last || word_idx_q == WORD_IDX_W'(IMEM_WORDS - 1)) begin
                            state_d = ST_RELEASE;
                        end else begin
                            word_idx_d = word_idx_q + WORD_IDX_W'(1);
                        end
                    end else begin
                        asm_d      = merged;
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    end
                end
            end
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN:     state_d = ST_RUN;
            default:    state_d = ST_LOAD;
        endcase
        load_ready_d = (state_d == ST_LOAD);
        core_rst_d   = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            asm_q        <= '0;
            load_ready_q <= 1'b1;
            core_rst_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            asm_q        <= asm_d;
            load_ready_q <= load_ready_d;
            core_rst_q   <= core_rst_d;
        end
    end

    assign load_ready = load_ready_q;
    assign core_rst   = core_rst_q;
    assign state      = state_q;

endmodule

// File: rtl/mips_mem.sv
// Memory responder for the core: registered instruction fetch, byte-wide data
// memory, and the program loader that fills instruction memory before release.
module mips_mem
    import mips_mem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_i_addr,
    output logic [31:0] mem_i,
    input  logic [7:0]  mem_rw_addr,
    output logic [7:0]  mem_r,
    input  logic [7:0]  mem_w,
    input  logic        mem_w_en,
    input  logic        breq,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        core_rst
);

    logic [31:0]           imem_q [IMEM_WORDS];
    logic [7:0]            dmem_q [DMEM_BYTES];
    logic [31:0]           mem_i_q, mem_i_d;
    logic [7:0]            mem_r_q, mem_r_d;
    state_e                state;
    logic                  imem_we;
    logic [WORD_IDX_W-1:0] imem_waddr;
    logic [31:0]           imem_wdata;
    logic                  unused_addr_bits;

    // Fetch is word-aligned; the byte-offset bits carry no meaning here.
    assign unused_addr_bits = ^mem_i_addr[1:0];

    mips_mem_loader #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .core_rst   (core_rst),
        .state      (state),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata)
    );

    always_comb begin
        mem_i_d = '0;
        if (state == ST_RUN) begin
            mem_i_d = imem_q[mem_i_addr[7:2]];
        end
        mem_r_d = mem_r_q;
        if (breq && !mem_w_en) begin
            mem_r_d = dmem_q[mem_rw_addr];
        end
    end

    // Memory arrays carry no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
        if (breq && mem_w_en) begin
            dmem_q[mem_rw_addr] <= mem_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_i_q <= '0;
            mem_r_q <= '0;
        end else begin
            mem_i_q <= mem_i_d;
            mem_r_q <= mem_r_d;
        end
    end

    assign mem_i = mem_i_q;
    assign mem_r = mem_r_q;

endmodule
